// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - UART receive FIFO bundle: capture/pop controls and head/status view
interface uart_rx_fifo_if #(
  parameter int W     = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          rx_valid;
  logic          rx_correct;
  logic [W-1:0]  rx_data;
  logic          pop;
  logic          clear;
  logic [W-1:0]  head_data;
  logic          head_correct;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [3:0]    err_cnt;

  modport master (
    output rx_valid, rx_correct, rx_data, pop, clear,
    input  head_data, head_correct, count, empty, full, overflow, err_cnt
  );

  modport slave (
    input  rx_valid, rx_correct, rx_data, pop, clear,
    output head_data, head_correct, count, empty, full, overflow, err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular byte FIFO behind the UART receiver with overflow and parity stats
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [3:0]    ERR_MAX  = 4'd15;

  logic           rx_valid_q;
  logic           pop_q;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_r;
  logic [AW:0]    count_nxt;
  logic           overflow_r;
  logic [3:0]     err_r;
  logic [W:0]     mem [DEPTH];

  logic push_ev;
  logic pop_ev;
  logic is_empty;
  logic is_full;
  logic do_push;
  logic do_pop;
  logic drop;

  assign push_ev  = bus.rx_valid & ~rx_valid_q;
  assign pop_ev   = bus.pop & ~pop_q;
  assign is_empty = (count_r == '0);
  assign is_full  = (count_r == CNT_FULL);

  // Full/empty are judged on the count before this cycle's pop, so a push
  // arriving with a pop while full is still dropped.
  assign do_push = push_ev & ~is_full & ~bus.clear;
  assign do_pop  = pop_ev & ~is_empty & ~bus.clear;
  assign drop    = push_ev & is_full & ~bus.clear;

  always_comb begin
    count_nxt = count_r;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count_r + CNT_ONE;
      2'b01:   count_nxt = count_r - CNT_ONE;
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      pop_q      <= bus.pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      err_r      <= '0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      err_r      <= '0;
    end else begin
      count_r <= count_nxt;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow_r <= 1'b1;
      end
      if (do_push && !bus.rx_correct && err_r != ERR_MAX) begin
        err_r <= err_r + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {bus.rx_correct, bus.rx_data};
    end
  end

  assign bus.head_data    = is_empty ? '0   : mem[rd_ptr][W-1:0];
  assign bus.head_correct = is_empty ? 1'b0 : mem[rd_ptr][W];
  assign bus.count        = count_r;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.overflow     = overflow_r;
  assign bus.err_cnt      = err_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.W(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic c);
    bus.rx_valid   = 1'b1;
    bus.rx_data    = d;
    bus.rx_correct = c;
    step();
    bus.rx_valid = 1'b0;
    step();
  endtask

  task automatic pop_once();
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    step();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_correct = 1'b0;
    bus.rx_data    = 8'h00;
    bus.pop        = 1'b0;
    bus.clear      = 1'b0;
    step();
    step();
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags count=%0d empty=%b full=%b exp 0 1 0", bus.count, bus.empty, bus.full);
    end
    checks++;
    if (bus.head_data !== 8'h00 || bus.head_correct !== 1'b0 || bus.overflow !== 1'b0 || bus.err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_outs head=%h hc=%b ovf=%b err=%0d exp 00 0 0 0",
               bus.head_data, bus.head_correct, bus.overflow, bus.err_cnt);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'hA5;
    bus.rx_correct = 1'b1;
    step();
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b0 || bus.head_data !== 8'hA5 || bus.head_correct !== 1'b1) begin
      errors++;
      $display("FAIL single_push count=%0d empty=%b head=%h hc=%b exp 1 0 a5 1",
               bus.count, bus.empty, bus.head_data, bus.head_correct);
    end
    bus.rx_valid = 1'b0;
    step();
    bus.pop = 1'b1;
    step();
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.head_data !== 8'h00) begin
      errors++;
      $display("FAIL single_pop count=%0d empty=%b head=%h exp 0 1 00", bus.count, bus.empty, bus.head_data);
    end
    bus.pop = 1'b0;
    step();
    // pop while empty must be ignored
    pop_once();
    checks++;
    if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop count=%0d ovf=%b exp 0 0", bus.count, bus.overflow);
    end
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < 16; i++) push_byte(8'(i), (i != 3));
    push_byte(8'h55, 1'b1);
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.err_cnt !== 4'd1) begin
      errors++;
      $display("FAIL full_ovf full=%b ovf=%b count=%0d err=%0d exp 1 1 16 1",
               bus.full, bus.overflow, bus.count, bus.err_cnt);
    end
    // simultaneous push and pop while full: pop wins, push dropped
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h77;
    bus.pop      = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.pop      = 1'b0;
    step();
    checks++;
    if (bus.count !== 5'd15 || bus.head_data !== 8'h01) begin
      errors++;
      $display("FAIL full_simul count=%0d head=%h exp 15 01", bus.count, bus.head_data);
    end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (bus.head_data !== 8'(i) || bus.head_correct !== (i != 3)) begin
        errors++;
        $display("FAIL full_order[%0d] head=%h hc=%b exp %h %b", i, bus.head_data, bus.head_correct, 8'(i), (i != 3));
      end
      pop_once();
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_drain empty=%b ovf=%b exp 1 1", bus.empty, bus.overflow);
    end
    do_clear();
    checks++;
    if (bus.overflow !== 1'b0 || bus.err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL full_clear ovf=%b err=%0d exp 0 0", bus.overflow, bus.err_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [$];
    for (int i = 0; i < 15; i++) push_byte(8'h20 + 8'(i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.head_data !== 8'h20 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_pop[%0d] head=%h exp %h", i, bus.head_data, 8'h20 + 8'(i));
      end
      pop_once();
    end
    for (int j = 0; j < 12; j++) push_byte(8'h40 + 8'(j), 1'b1);
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full count=%0d full=%b ovf=%b exp 16 1 1", bus.count, bus.full, bus.overflow);
    end
    for (int i = 10; i < 15; i++) exp_q.push_back(8'h20 + 8'(i));
    for (int j = 0; j < 11; j++) exp_q.push_back(8'h40 + 8'(j));
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.head_data !== exp_q[k]) begin
        errors++;
        $display("FAIL wrap_order[%0d] head=%h exp %h", k, bus.head_data, exp_q[k]);
      end
      pop_once();
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_empty empty=%b exp 1", bus.empty);
    end
    do_clear();
  endtask

  task automatic test_back_to_back();
    // simultaneous push and pop while empty: push wins
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    bus.pop      = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    bus.pop      = 1'b0;
    step();
    checks++;
    if (bus.count !== 5'd1 || bus.head_data !== 8'h5A) begin
      errors++;
      $display("FAIL empty_simul count=%0d head=%h exp 1 5a", bus.count, bus.head_data);
    end
    do_clear();
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    push_byte(8'h63, 1'b1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h64;
    bus.pop      = 1'b1;
    step();
    checks++;
    if (bus.count !== 5'd3 || bus.head_data !== 8'h62) begin
      errors++;
      $display("FAIL mid_simul count=%0d head=%h exp 3 62", bus.count, bus.head_data);
    end
    bus.rx_valid = 1'b0;
    bus.pop      = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.head_data !== 8'h62 + 8'(i)) begin
        errors++;
        $display("FAIL mid_order[%0d] head=%h exp %h", i, bus.head_data, 8'h62 + 8'(i));
      end
      pop_once();
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_empty empty=%b exp 1", bus.empty);
    end
  endtask

  task automatic test_err_cnt();
    do_clear();
    for (int i = 0; i < 10; i++) push_byte(8'h80 + 8'(i), 1'b0);
    checks++;
    if (bus.err_cnt !== 4'd10) begin
      errors++;
      $display("FAIL err_batch1 err=%0d exp 10", bus.err_cnt);
    end
    do_clear();
    for (int i = 0; i < 10; i++) push_byte(8'h90 + 8'(i), 1'b0);
    checks++;
    if (bus.err_cnt !== 4'd10) begin
      errors++;
      $display("FAIL err_batch2 err=%0d exp 10", bus.err_cnt);
    end
    do_clear();
    for (int i = 0; i < 20; i++) push_byte(8'hA0 + 8'(i), 1'b0);
    checks++;
    if (bus.err_cnt !== 4'd15 || bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL err_sat err=%0d count=%0d ovf=%b exp 15 16 1", bus.err_cnt, bus.count, bus.overflow);
    end
    do_clear();
  endtask

  task automatic test_hold_and_reset();
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'h99;
    bus.rx_correct = 1'b1;
    for (int i = 0; i < 100; i++) step();
    checks++;
    if (bus.count !== 5'd1 || bus.head_data !== 8'h99) begin
      errors++;
      $display("FAIL hold_one count=%0d head=%h exp 1 99", bus.count, bus.head_data);
    end
    bus.rx_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i), 1'b0);
    checks++;
    if (bus.count !== 5'd5 || bus.err_cnt !== 4'd4) begin
      errors++;
      $display("FAIL pre_rst count=%0d err=%0d exp 5 4", bus.count, bus.err_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.head_data !== 8'h00 ||
        bus.head_correct !== 1'b0 || bus.err_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_rst count=%0d empty=%b head=%h hc=%b err=%0d exp 0 1 00 0 0",
               bus.count, bus.empty, bus.head_data, bus.head_correct, bus.err_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_back_to_back();
    test_err_cnt();
    test_hold_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer that sits directly downstream of the UART receiver on the FPGA board top.
- Captures each newly received byte together with its parity-correct flag into a circular FIFO.
- The user pops entries with a button pulse. The oldest entry is presented for the seven-segment display.
- Also tracks overflow and parity-error statistics, so bursts of traffic are not lost between button presses.

Parameters:
- W, 8, data byte width (matches the UART n parameter).
- DEPTH, 16, FIFO entries; must be a power of two, at least 2. AW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  UART receive-valid level; a new byte is signalled by its 0->1 transition.
- rx_correct  input  1  UART parity-check result for the current byte.
- rx_data  input  W  UART received byte.
- pop  input  1  pop request from a debounced button, level; acted on at its 0->1 transition.
- clear  input  1  synchronous flush of contents and statistics, level-sensitive.
- head_data  output  W  oldest stored byte; 0 when empty.
- head_correct  output  1  parity flag of the oldest entry; 0 when empty.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- err_cnt  output  4  count of captured bytes with rx_correct=0; saturates at 15.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, count, overflow and err_cnt go to 0.
  - empty=1, full=0, head_data=0, head_correct=0.
  - The edge-detect registers for rx_valid and pop are cleared to 0. A level already high when reset releases therefore counts as an edge on the first clock.
  - Memory contents are don't-care.
- Edge detect:
  - push_ev = rx_valid & ~rx_valid_q.
  - pop_ev = pop & ~pop_q.
  - Both _q registers update every cycle.
- Push:
  - On push_ev with full=0, {rx_correct, rx_data} are sampled in the same cycle and written to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH.
- Pop:
  - On pop_ev with empty=0, rd_ptr increments modulo DEPTH.
  - A pop_ev while empty is ignored: no pointer or count change and no flag.
- Count rules:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle, FIFO not empty and not full: both take effect and count is unchanged.
  - Simultaneous push and pop while full: the pop takes effect, the push is dropped and overflow is set. count becomes DEPTH-1.
  - Simultaneous push and pop while empty: the push takes effect, the pop is ignored. count becomes 1.
- Overflow:
  - A push_ev while full=1 (evaluated before this cycle's pop) drops the byte and sets overflow.
  - overflow stays set until clear or reset.
- err_cnt increments on every accepted push with rx_correct=0 and holds at 15. Dropped bytes are not counted.
- Head output:
  - head_data and head_correct are combinational from mem[rd_ptr], gated to 0 when empty.
  - Latency: a byte pushed in cycle N is visible on head_data and count from cycle N+1.
- Flags: empty and full are derived combinationally from the registered count.
- clear:
  - Pointers, count, overflow and err_cnt go to 0 at the next edge.
  - clear has priority over a push or pop in the same cycle; both are discarded.
  - The edge-detect registers still update.
- Wrap-around: pointers are AW bits and wrap naturally. Full and empty are distinguished by count, not by pointer comparison.
- rx_valid held high for many cycles produces exactly one push. It must return low before the next byte can be captured.

Test Plan:
- Reset, then pulse rx_valid with rx_data=8'hA5, rx_correct=1 -> next cycle count=1, empty=0, head_data=A5, head_correct=1. Raise pop -> count=0, empty=1, head_data=00.
- Push 16 bytes 8'h00..8'h0F, then push 8'h55 -> full=1, overflow=1, count=16, 8'h55 absent. Pop 16 times -> reads 00..0F in order, then empty=1. overflow stays 1 until clear, which sets overflow=0 and err_cnt=0.
- Fill to 15, pop 10, then push 12 more (pointer wrap) -> count=17-10 capped: the 12th push overflows. Verify FIFO order across the wrap boundary and count=16.
- Raise rx_valid and pop in the same cycle with count=3 -> count stays 3; head advances to the second-oldest byte; the new byte is the last one popped.
- Push 20 bytes with rx_correct=0 into a FIFO cleared between batches of 10 -> err_cnt reaches 10, then 10 again after clear. Without clear, err_cnt saturates at 15.
- Hold rx_valid high for 100 cycles -> exactly one entry added. Assert rst_n=0 mid-operation with count=5 -> immediately count=0, empty=1, outputs 0.
